// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA timing generator with four built-in test patterns (solid colour,
//   colour bars, checkerboard, bouncing box). A horizontal/vertical counter
//   pair advances on each pix_en tick. Every output is registered from the
//   counter value present before the tick, so all outputs share a one-tick
//   latency. Pattern mode and colour are latched once per frame, on the tick
//   that registers pixel (0,0).
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pix_en       pixel tick; nothing advances while low
//   mode[1:0]    0 solid, 1 colour bars, 2 checkerboard, 3 moving box
//   sw_color[2:0]{R,G,B} enables for solid mode and the box colour
//   hsync/vsync  sync pulses, active level SYNC_ACT
//   video_on     high inside the visible area
//   pixel_x/y    registered horizontal/vertical count
//   frame_start  one-clk pulse on the tick that registers count (0,0)
//   red/green/blue colour channels, COLOR_W bits each
//
// Both H and V totals must not exceed 1024 (10-bit counters).

module vga_pattern_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_W   = 4,
  parameter int SYNC_ACT  = 0,
  parameter int BOX_SIZE  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic [1:0]         mode,
  input  logic [2:0]         sw_color,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [9:0]         pixel_x,
  output logic [9:0]         pixel_y,
  output logic               frame_start,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_DISPLAY / 8;

  // 11-bit constants so comparisons against zero-extended counters stay
  // width-matched even when a boundary equals 1024.
  localparam logic [10:0] H_DISP_L = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_DISP_L = 11'(V_DISPLAY);
  localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_LIM    = 11'(H_DISPLAY - BOX_SIZE);
  localparam logic [10:0] Y_LIM    = 11'(V_DISPLAY - BOX_SIZE);
  localparam logic [10:0] BOX_L    = 11'(BOX_SIZE);
  localparam logic        SYNC_ON  = (SYNC_ACT != 0);

  // counters
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [10:0] h_ext, v_ext;

  // per-frame state
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  color_q, color_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dx_q, dx_d;      // 1 = moving +1
  logic        dy_q, dy_d;

  // registered outputs
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic [9:0]         pixel_x_q, pixel_x_d;
  logic [9:0]         pixel_y_q, pixel_y_d;
  logic               frame_start_q, frame_start_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;

  // pixel-path intermediates
  logic        at_origin;
  logic        tick_origin;
  logic        vis;
  logic        hs_in, vs_in;
  logic        in_box;
  logic [10:0] box_x_ext, box_y_ext;
  logic [2:0]  bar_idx;
  logic [2:0]  rgb;

  assign h_ext       = {1'b0, h_cnt_q};
  assign v_ext       = {1'b0, v_cnt_q};
  assign at_origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign tick_origin = pix_en && at_origin;

  // ---------------------------------------------------------------- counters
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_ext == H_LAST) begin
        h_cnt_d = '0;
        if (v_ext == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // ----------------------------------------------------- per-frame settings
  // The box steps once per frame regardless of mode, so switching back to
  // mode 3 picks up where the motion would have been. Reaching a limit
  // flips the direction instead of stepping, so the box rests one frame at
  // each wall.
  always_comb begin
    mode_d  = mode_q;
    color_d = color_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (tick_origin) begin
      mode_d  = mode;
      color_d = sw_color;

      if (dx_q && ({1'b0, box_x_q} == X_LIM)) begin
        dx_d = 1'b0;
      end else if (!dx_q && (box_x_q == '0)) begin
        dx_d = 1'b1;
      end else if (dx_q) begin
        box_x_d = box_x_q + 10'd1;
      end else begin
        box_x_d = box_x_q - 10'd1;
      end

      if (dy_q && ({1'b0, box_y_q} == Y_LIM)) begin
        dy_d = 1'b0;
      end else if (!dy_q && (box_y_q == '0)) begin
        dy_d = 1'b1;
      end else if (dy_q) begin
        box_y_d = box_y_q + 10'd1;
      end else begin
        box_y_d = box_y_q - 10'd1;
      end
    end
  end

  // ------------------------------------------------------------ pixel path
  // The *_d versions of mode/colour/box are used so that pixel (0,0), which
  // is registered on the same tick that latches them, already belongs to the
  // new frame. Off the origin tick the *_d values equal the *_q values.
  always_comb begin
    vis       = (h_ext < H_DISP_L) && (v_ext < V_DISP_L);
    hs_in     = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_in     = (v_ext >= VS_BEG) && (v_ext < VS_END);
    box_x_ext = {1'b0, box_x_d};
    box_y_ext = {1'b0, box_y_d};
    in_box    = (h_ext >= box_x_ext) && (h_ext < box_x_ext + BOX_L) &&
                (v_ext >= box_y_ext) && (v_ext < box_y_ext + BOX_L);

    // Bar index as a count of crossed bar boundaries; pixels past the eighth
    // boundary (H_DISPLAY not divisible by 8) stay on bar 7.
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_ext >= 11'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end

    rgb = 3'b000;
    case (mode_d)
      2'd0:    rgb = color_d;
      2'd1:    rgb = bar_idx;
      2'd2:    rgb = {3{h_ext[5] ^ v_ext[5]}};
      default: rgb = in_box ? color_d : 3'b000;
    endcase
    if (!vis) begin
      rgb = 3'b000;
    end
  end

  // ------------------------------------------------------- output registers
  // frame_start is the one output that does not hold across idle clocks:
  // it is a single-clk pulse.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    frame_start_d = tick_origin;
    if (pix_en) begin
      hsync_d    = hs_in ? SYNC_ON : ~SYNC_ON;
      vsync_d    = vs_in ? SYNC_ON : ~SYNC_ON;
      video_on_d = vis;
      pixel_x_d  = h_cnt_q;
      pixel_y_d  = v_cnt_q;
      red_d      = {COLOR_W{rgb[2]}};
      green_d    = {COLOR_W{rgb[1]}};
      blue_d     = {COLOR_W{rgb[0]}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= '0;
      color_q       <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      color_q       <= color_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen using a reduced timing so full frames, periods
// and box bounces fit in a short run. Stimulus pushes the expected output of
// every clock into a queue; a monitor pops and compares one clock later.
module tb_vga_pattern_gen;

  localparam int HD = 42, HFP = 1, HSW = 2, HBP = 1;
  localparam int VD = 36, VFP = 1, VSW = 2, VBP = 1;
  localparam int BOX = 32;
  localparam int SYNC_ACT = 0;
  localparam int HT = HD + HFP + HSW + HBP;
  localparam int VT = VD + VFP + VSW + VBP;
  localparam int F  = HT * VT;
  localparam logic ACT = 1'(SYNC_ACT);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } out_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_en;
  logic [1:0] mode;
  logic [2:0] sw_color;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] red, green, blue;

  vga_pattern_gen #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COLOR_W(4), .SYNC_ACT(SYNC_ACT), .BOX_SIZE(BOX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .mode(mode),
    .sw_color(sw_color), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t exp_q[$];

  // reference model state
  int   m_h, m_v, m_mode, m_col, m_bx, m_by, m_dx, m_dy;
  out_t m_out;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.hs = hsync; o.vs = vsync; o.von = video_on; o.fs = frame_start;
    o.x = pixel_x; o.y = pixel_y; o.r = red; o.g = green; o.b = blue;
    return o;
  endfunction

  function automatic out_t model_pixel(int h, int v, int md, int col, int bx, int by);
    out_t o;
    int   rgb;
    o.hs  = (h >= HD + HFP && h < HD + HFP + HSW) ? ACT : !ACT;
    o.vs  = (v >= VD + VFP && v < VD + VFP + VSW) ? ACT : !ACT;
    o.von = (h < HD) && (v < VD);
    o.fs  = 1'b0;
    o.x   = 10'(h);
    o.y   = 10'(v);
    rgb   = 0;
    if (o.von) begin
      case (md)
        0: rgb = col;
        1: begin
          rgb = h / (HD / 8);
          if (rgb > 7) rgb = 7;
        end
        2: rgb = (((h / 32) % 2) != ((v / 32) % 2)) ? 7 : 0;
        default: rgb = (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? col : 0;
      endcase
    end
    o.r = ((rgb & 4) != 0) ? 4'hF : 4'h0;
    o.g = ((rgb & 2) != 0) ? 4'hF : 4'h0;
    o.b = ((rgb & 1) != 0) ? 4'hF : 4'h0;
    return o;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 0; m_col = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_out = model_pixel(HD, VD, 0, 0, 0, 0);  // off-screen: all colour 0
    m_out.hs = !ACT; m_out.vs = !ACT; m_out.x = '0; m_out.y = '0;
  endtask

  task automatic model_step(input bit en, input int md, input int col);
    bit origin;
    if (!en) begin
      m_out.fs = 1'b0;
    end else begin
      origin = (m_h == 0 && m_v == 0);
      if (origin) begin
        m_mode = md;
        m_col  = col;
        if (m_dx == 1 && m_bx == HD - BOX) m_dx = -1;
        else if (m_dx == -1 && m_bx == 0)  m_dx = 1;
        else                               m_bx += m_dx;
        if (m_dy == 1 && m_by == VD - BOX) m_dy = -1;
        else if (m_dy == -1 && m_by == 0)  m_dy = 1;
        else                               m_by += m_dy;
      end
      m_out    = model_pixel(m_h, m_v, m_mode, m_col, m_bx, m_by);
      m_out.fs = origin;
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
    exp_q.push_back(m_out);
  endtask

  task automatic tick(input bit en, input logic [1:0] md, input logic [2:0] col);
    @(negedge clk);
    pix_en   = en;
    mode     = md;
    sw_color = col;
    model_step(en, int'(md), int'(col));
  endtask

  // scoreboard monitor
  out_t mon_exp, mon_got;
  int   n_printed = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = dut_out();
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_bad++;
        if (n_printed < 20) begin
          n_printed++;
          $display("FAIL scoreboard @%0t x=%0d y=%0d: got %h expected %h",
                   $time, mon_exp.x, mon_exp.y, mon_got, mon_exp);
        end
      end
    end
  end

  // directed timing/pixel checks
  int   meas_mult   = 0;
  bit   chk_checker = 1'b0;
  int   cyc = 0, last_fs = -1, hs_start = -1, vs_start = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (meas_mult != 0) begin
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", longint'(cyc - last_fs), longint'(F * meas_mult));
        last_fs = cyc;
      end
      if (hsync == ACT && prev_hs != ACT) begin
        chk("hsync_start_x", longint'(pixel_x), longint'(HD + HFP));
        hs_start = cyc;
      end
      if (hsync != ACT && prev_hs == ACT && hs_start >= 0)
        chk("hsync_width", longint'(cyc - hs_start), longint'(HSW * meas_mult));
      if (vsync == ACT && prev_vs != ACT) begin
        chk("vsync_start_y", longint'(pixel_y), longint'(VD + VFP));
        vs_start = cyc;
      end
      if (vsync != ACT && prev_vs == ACT && vs_start >= 0)
        chk("vsync_width", longint'(cyc - vs_start), longint'(VSW * HT * meas_mult));
    end else begin
      last_fs = -1; hs_start = -1; vs_start = -1;
    end
    if (chk_checker && m_mode == 2 && video_on && pixel_x == 10'd32) begin
      if (pixel_y == 10'd0)  chk("checker_32_0",  longint'({red, green, blue}), 64'hFFF);
      if (pixel_y == 10'd32) chk("checker_32_32", longint'({red, green, blue}), 64'h000);
    end
    prev_hs = hsync;
    prev_vs = vsync;
  end

  initial begin
    pix_en = 1'b0; mode = 2'd0; sw_color = 3'd0;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1 chk("reset_values", longint'(dut_out()), longint'(m_out));
    @(negedge clk);
    reset_n = 1'b1;

    // continuous ticks, solid magenta
    meas_mult = 1;
    for (int i = 0; i < (F * 11) / 5; i++) tick(1'b1, 2'd0, 3'b101);
    meas_mult = 0;
    tick(1'b0, 2'd0, 3'b101);

    // pix_en every 4th clock, random mode/colour changing mid-frame
    meas_mult = 4;
    for (int i = 0; i < 4 * ((F * 11) / 5); i++)
      tick((i % 4) == 3, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    meas_mult = 0;

    // bars, switched to checker mid-frame, irregular ticks
    for (int i = 0; i < (F * 3) / 2; i++)
      tick($urandom_range(0, 3) != 0, 2'd1, 3'($urandom_range(0, 7)));
    chk_checker = 1'b1;
    for (int i = 0; i < 3 * F; i++)
      tick($urandom_range(0, 3) != 0, 2'd2, 3'($urandom_range(0, 7)));
    chk_checker = 1'b0;

    // moving box over enough frames for both walls on each axis
    for (int i = 0; i < 18 * F; i++)
      tick(1'b1, 2'd3, 3'($urandom_range(1, 7)));

    // asynchronous reset mid-frame at (20,15)
    for (int i = 0; i < F && !(m_h == 21 && m_v == 15); i++) tick(1'b1, 2'd0, 3'b111);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 model_reset();
    chk("async_reset", longint'(dut_out()), longint'(m_out));
    @(negedge clk);
    @(negedge clk);
    pix_en  = 1'b0;
    reset_n = 1'b1;
    meas_mult = 1;
    for (int i = 0; i < (F * 6) / 5; i++) tick(1'b1, 2'd0, 3'($urandom_range(0, 7)));
    meas_mult = 0;
    for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 3'd0);

    repeat (3) @(posedge clk);
    #3 chk("queue_drained", longint'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- COLOR_W, 4, bits per colour channel.
- SYNC_ACT, 0, active level of hsync and vsync.
- BOX_SIZE, 32, moving-box edge length in pixels.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock; the single clock.
- reset_n, in, 1, asynchronous active-low reset.
- pix_en, in, 1, pixel tick; all state advances only when high.
- mode, in, 2, 0 solid, 1 colour bars, 2 checkerboard, 3 moving box.
- sw_color, in, 3, {R,G,B} enables for solid mode and box colour.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- video_on, out, 1, high inside the visible area.
- pixel_x, out, 10, registered horizontal count.
- pixel_y, out, 10, registered vertical count.
- frame_start, out, 1, one-clk pulse at count (0,0).
- red, out, COLOR_W, red channel.
- green, out, COLOR_W, green channel.
- blue, out, COLOR_W, blue channel.

Function
REQ-003 Totals SHALL be H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP and V_TOTAL likewise; both SHALL be <= 1024.
REQ-004 h_cnt SHALL increment on each clk with pix_en=1 and wrap from H_TOTAL-1 to 0.
REQ-005 v_cnt SHALL increment when h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0 when h_cnt also wraps.
REQ-006 When pix_en=0, every register SHALL hold, including outputs.
REQ-007 Every output SHALL be registered, updating on pix_en clocks only, and SHALL reflect the counter value present before that clock edge (latency 1 tick, all outputs aligned).
REQ-008 hsync SHALL equal SYNC_ACT iff H_DISPLAY+H_FP <= h_cnt < H_DISPLAY+H_FP+H_SYNC; otherwise it SHALL equal ~SYNC_ACT.
REQ-009 vsync SHALL follow the same rule as REQ-008 using the V parameters and v_cnt.
REQ-010 video_on SHALL be 1 iff h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
REQ-011 When video_on=0, red, green and blue SHALL be 0.
REQ-012 frame_start SHALL be high for exactly one clk, on the pix_en clock that registers h_cnt=0, v_cnt=0.
REQ-013 mode and sw_color SHALL be sampled into active registers only on the clock asserting frame_start; changes mid-frame SHALL have no effect until the next frame.
REQ-014 Mode 0 (solid): each channel SHALL be all-ones if its sw_color bit is set, else 0.
REQ-015 Mode 1 (bars): eight vertical bars of width H_DISPLAY/8; bar index k = 0..7 SHALL drive {R,G,B} = bits {k[2],k[1],k[0]} as full-scale or 0; remainder pixels SHALL use bar 7.
REQ-016 Mode 2 (checker): a pixel SHALL be white if x[5]^y[5] = 1, else black.
REQ-017 Mode 3 (box): pixels with box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE SHALL take the sw_color colour; all other pixels SHALL be black.
REQ-018 box_x and box_y SHALL update once per frame, at frame_start, by ±1 according to the direction bits dx and dy.
REQ-019 Bounce: when box_x reaches H_DISPLAY-BOX_SIZE with dx=+1, dx SHALL flip to -1 in that same update (x does not step that frame); the same SHALL apply when box_x reaches 0 with dx=-1.
REQ-020 The Y axis SHALL bounce identically, with limits 0 and V_DISPLAY-BOX_SIZE.
REQ-021 Box position SHALL advance in every mode, so that returning to mode 3 is continuous.

Reset
REQ-022 reset_n=0 SHALL immediately, independent of clk, force all of the following:
- h_cnt, v_cnt, pixel_x and pixel_y to 0.
- hsync and vsync to ~SYNC_ACT.
- video_on, frame_start, red, green and blue to 0.
- box_x = box_y = 0, dx = dy = +1.
- active mode = 0 and active colour = 0.
REQ-023 After reset_n rises, the first pix_en clock SHALL register count (0,0) and assert frame_start.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no partial-line recovery.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then pix_en=1 continuously -> frame_start every 800*525 = 420000 clocks; hsync low for 96 ticks starting at x=656; vsync low on lines 490-491.
- pix_en every 4th clock -> all periods exactly 4x, and outputs constant between ticks.
- mode=0, sw_color=3'b101 -> during visible area red=blue=4'hF, green=0; outside it all channels 0.
- mode switched 1->2 mid-frame -> bars continue until the next frame_start, then checker; pixel (32,0) white, (32,32) black.
- mode=3 for 700 frames -> box_x reaches 608 at frame 608, then decreases; box_y turns at 448.
- reset_n pulsed low at x=300, y=200 -> outputs take reset values asynchronously; restart at (0,0) with frame_start.
